// File: rtl/counter_pkg.sv
// Constants shared by the team's binary up and down counters.
package counter_pkg;

  localparam int DEFAULT_WIDTH     = 3;
  localparam int DEFAULT_RESET_VAL = 0;

  // Terminal behaviour when a down count reaches zero.
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_STOP = 1'b1;

endpackage

// File: rtl/d_ff_ar.sv
// Single-bit D flip-flop with asynchronous active-low reset.
// The reset value comes in as a port, so one cell covers set and clear flops.
module d_ff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= rst_val;
    else        q <= d;
  end

endmodule

// File: rtl/down_counter_n_bit.sv
// N-bit binary down counter: gate-level borrow chain, load mux and flag gates
// around d_ff_ar cells. The borrow output is meant to drive en of the next stage.
module down_counter_n_bit
  import counter_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter bit               STOP_AT_ZERO = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q_b,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic             cnt_en;
  logic             borrow_q;
  logic             borrow_d;
  logic             done_q;
  logic             done_d;

  assign zero = (count_q == '0);

  // In stop mode the chain is starved at zero, so the count simply holds.
  assign cnt_en    = en && !load && !(STOP_AT_ZERO && zero);
  assign toggle[0] = cnt_en;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign toggle[i] = cnt_en & ~|count_q[i-1:0];
  end

  always_comb begin
    count_d  = load ? d : (count_q ^ toggle);
    borrow_d = en && !load && zero && !STOP_AT_ZERO;
    done_d   = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (en) begin
      done_d = STOP_AT_ZERO && (zero || (count_q == WIDTH'(1)));
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_count_ff
    d_ff_ar u_ff (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RESET_VAL[i]),
      .d       (count_d[i]),
      .q       (count_q[i])
    );
  end

  d_ff_ar u_borrow_ff (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (1'b0),
    .d       (borrow_d),
    .q       (borrow_q)
  );

  d_ff_ar u_done_ff (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val (1'b0),
    .d       (done_d),
    .q       (done_q)
  );

  assign Q_b    = count_q;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule

// File: tb/tb_down_counter_n_bit.sv
// Bench for down_counter_n_bit: wrap and stop instances, a cascaded pair
// and a 1-bit instance sharing one clock and reset.
module tb_down_counter_n_bit;
  import counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       w_en = 0, w_load = 0;
  logic [2:0] w_d  = '0;
  logic [2:0] w_q;
  logic       w_z, w_b, w_dn;

  logic       s_en = 0, s_load = 0;
  logic [2:0] s_d  = '0;
  logic [2:0] s_q;
  logic       s_z, s_b, s_dn;

  logic       c_en = 0;
  logic [2:0] lo_q, hi_q;
  logic       lo_z, lo_b, lo_dn, hi_z, hi_b, hi_dn;

  logic       w1_en = 0;
  logic [0:0] w1_q;
  logic       w1_z, w1_b, w1_dn;

  down_counter_n_bit #(.WIDTH(3), .STOP_AT_ZERO(MODE_WRAP), .RESET_VAL(3'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(w_en), .load(w_load), .d(w_d),
    .Q_b(w_q), .zero(w_z), .borrow(w_b), .done(w_dn));

  down_counter_n_bit #(.WIDTH(3), .STOP_AT_ZERO(MODE_STOP), .RESET_VAL(3'd0)) u_stop (
    .clk(clk), .rst_n(rst_n), .en(s_en), .load(s_load), .d(s_d),
    .Q_b(s_q), .zero(s_z), .borrow(s_b), .done(s_dn));

  down_counter_n_bit #(.WIDTH(3), .STOP_AT_ZERO(MODE_WRAP), .RESET_VAL(3'd0)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(c_en), .load(1'b0), .d(3'd0),
    .Q_b(lo_q), .zero(lo_z), .borrow(lo_b), .done(lo_dn));

  down_counter_n_bit #(.WIDTH(3), .STOP_AT_ZERO(MODE_WRAP), .RESET_VAL(3'd0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(lo_b), .load(1'b0), .d(3'd0),
    .Q_b(hi_q), .zero(hi_z), .borrow(hi_b), .done(hi_dn));

  down_counter_n_bit #(.WIDTH(1), .STOP_AT_ZERO(MODE_WRAP), .RESET_VAL(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .en(w1_en), .load(1'b0), .d(1'b0),
    .Q_b(w1_q), .zero(w1_z), .borrow(w1_b), .done(w1_dn));

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act);
    logic [7:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h but scoreboard is empty", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       sel;   // 0 = wrap instance, 1 = stop instance
    logic       load;
    logic [2:0] d;
    logic       en;
    logic [2:0] q;
    logic       z;
    logic       b;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lo_m, hi_m, nl, nh;
    logic       b_m, nb, w1_m, w1b_m;

    // wrap mode: nine enabled edges from reset, then load/en priority
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd7, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd6, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd5, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd4, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd3, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd2, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd1, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd0, 1, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd7, 0, 1, 0});
    vecs.push_back(vec_t'{0, 1, 3'd5, 1, 3'd5, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 0, 3'd5, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd4, 0, 0, 0});
    vecs.push_back(vec_t'{0, 1, 3'd0, 0, 3'd0, 1, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 0, 3'd0, 1, 0, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd7, 0, 1, 0});
    vecs.push_back(vec_t'{0, 0, 3'd0, 1, 3'd6, 0, 0, 0});
    // stop mode: count to zero, hold, done behaviour
    vecs.push_back(vec_t'{1, 1, 3'd2, 0, 3'd2, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd1, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 0, 3'd0, 0, 3'd0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 1, 3'd0, 0, 3'd0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 0, 3'd0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd0, 1, 0, 1});
    vecs.push_back(vec_t'{1, 1, 3'd3, 1, 3'd3, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd2, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd1, 0, 0, 0});
    vecs.push_back(vec_t'{1, 0, 3'd0, 1, 3'd0, 1, 0, 1});

    // reset state while rst_n is held low
    #2;
    exp_q.push_back({2'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    check("reset_wrap", {2'b0, w_q, w_z, w_b, w_dn});
    exp_q.push_back({2'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    check("reset_stop", {2'b0, s_q, s_z, s_b, s_dn});
    #10;
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      w_load = 0; w_en = 0; w_d = '0;
      s_load = 0; s_en = 0; s_d = '0;
      if (vecs[i].sel) begin
        s_load = vecs[i].load; s_d = vecs[i].d; s_en = vecs[i].en;
      end else begin
        w_load = vecs[i].load; w_d = vecs[i].d; w_en = vecs[i].en;
      end
      exp_q.push_back({2'b0, vecs[i].q, vecs[i].z, vecs[i].b, vecs[i].dn});
      @(posedge clk); #1;
      if (vecs[i].sel) check($sformatf("vec%0d_stop", i), {2'b0, s_q, s_z, s_b, s_dn});
      else             check($sformatf("vec%0d_wrap", i), {2'b0, w_q, w_z, w_b, w_dn});
    end
    w_load = 0; w_en = 0; s_load = 0; s_en = 0;

    // asynchronous reset in the middle of a count
    w_load = 1; w_d = 3'd3;
    exp_q.push_back({2'b0, 3'd3, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("mid_load3", {2'b0, w_q, w_z, w_b, w_dn});
    w_load = 0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back({2'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    check("async_rst_wrap", {2'b0, w_q, w_z, w_b, w_dn});
    exp_q.push_back({2'b0, 3'd0, 1'b1, 1'b0, 1'b0});
    check("async_rst_stop", {2'b0, s_q, s_z, s_b, s_dn});
    @(negedge clk);
    rst_n = 1'b1;
    w_en  = 1'b1;
    exp_q.push_back({2'b0, 3'd7, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("resume_7", {2'b0, w_q, w_z, w_b, w_dn});
    exp_q.push_back({2'b0, 3'd6, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("resume_6", {2'b0, w_q, w_z, w_b, w_dn});
    w_en = 1'b0;

    // cascaded pair: upper stage lags the lower wrap by one edge
    lo_m = 3'd0; hi_m = 3'd0; b_m = 1'b0;
    c_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nh = b_m ? hi_m - 3'd1 : hi_m;
      nb = (lo_m == 3'd0);
      nl = lo_m - 3'd1;
      hi_m = nh; b_m = nb; lo_m = nl;
      exp_q.push_back({1'b0, hi_m, lo_m, b_m});
      @(posedge clk); #1;
      check($sformatf("cascade%0d", i), {1'b0, hi_q, lo_q, lo_b});
    end
    c_en = 1'b0;
    exp_q.push_back({2'b0, 3'd6, 3'd0});
    check("cascade_total", {2'b0, hi_q, lo_q});

    // 1-bit wrap mode
    w1_m = 1'b0;
    w1_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w1b_m = (w1_m == 1'b0);
      w1_m  = ~w1_m;
      exp_q.push_back({5'b0, w1_m, ~w1_m, w1b_m});
      @(posedge clk); #1;
      check($sformatf("w1_%0d", i), {5'b0, w1_q, w1_z, w1_b});
    end
    w1_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
